// File: rtl/apb_mem_arbiter_if.sv
// APB requester bundle for apb_mem_arbiter: one slice per master.
// Masters drive the request side and the arbiter drives the response side.
interface apb_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int MEM_WIDTH   = 32
);
    logic [NUM_MASTERS-1:0]           psel;
    logic [NUM_MASTERS-1:0]           penable;
    logic [NUM_MASTERS-1:0]           pwrite;
    logic [NUM_MASTERS*32-1:0]        paddr;
    logic [NUM_MASTERS*MEM_WIDTH-1:0] pwdata;
    logic [NUM_MASTERS*MEM_WIDTH-1:0] prdata;
    logic [NUM_MASTERS-1:0]           pready;
    logic [NUM_MASTERS-1:0]           pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter letting NUM_MASTERS APB requesters share one memory.
// Optional macro APB_ARB_ADDR_CHECK_EN adds an address range check with pslverr.
module apb_mem_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          MEM_DEPTH   = 16,
    parameter int          MEM_WIDTH   = 32,
    parameter logic [31:0] BASEADDRESS = '0,
    parameter int          ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_mem_arbiter_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [MEM_WIDTH-1:0]  mem_wr_data,
    input  logic [MEM_WIDTH-1:0]  mem_rd_data
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             req_found;
    logic [IDX_W-1:0] req_idx;

    logic                 sel_psel;
    logic                 sel_pen;
    logic                 sel_wr;
    logic [31:0]          sel_addr;
    logic [MEM_WIDTH-1:0] sel_wdata;
    logic                 in_range;

    assign sel_psel  = bus.psel[gnt_q];
    assign sel_pen   = bus.penable[gnt_q];
    assign sel_wr    = bus.pwrite[gnt_q];
    assign sel_addr  = bus.paddr[int'(gnt_q)*32 +: 32];
    assign sel_wdata = bus.pwdata[int'(gnt_q)*MEM_WIDTH +: MEM_WIDTH];

`ifdef APB_ARB_ADDR_CHECK_EN
    assign in_range = (sel_addr >= BASEADDRESS) &&
                      ((sel_addr - BASEADDRESS) < 32'(MEM_DEPTH));
`else
    assign in_range = 1'b1;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // First requesting master at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!req_found && bus.psel[idx]) begin
                req_found = 1'b1;
                req_idx   = IDX_W'(idx);
            end
        end
    end

    // Next state and all bus/memory outputs; reset forces outputs quiet.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        bus.pready  = '0;
        bus.pslverr = '0;
        bus.prdata  = '0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_data = '0;
        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    gnt_d   = req_idx;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr    = ADDR_WIDTH'(sel_addr - BASEADDRESS);
                mem_wr_data = sel_wdata;
                if (!sel_psel) begin
                    state_d = IDLE;
                end else if (sel_pen) begin
                    bus.pready[gnt_q] = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = (int'(gnt_q) == NUM_MASTERS - 1) ?
                               '0 : gnt_q + 1'b1;
                    if (in_range) begin
                        mem_wr_en = sel_wr;
                        mem_rd_en = !sel_wr;
                        if (!sel_wr) begin
                            bus.prdata[int'(gnt_q)*MEM_WIDTH +: MEM_WIDTH]
                                = mem_rd_data;
                        end
                    end else begin
                        bus.pslverr[gnt_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            bus.pready  = '0;
            bus.pslverr = '0;
            bus.prdata  = '0;
            mem_addr    = '0;
            mem_wr_en   = 1'b0;
            mem_rd_en   = 1'b0;
            mem_wr_data = '0;
        end
    end
endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Bench for apb_mem_arbiter: directed scenarios, then random traffic
// checked against a round-robin and memory reference model.
module tb_apb_mem_arbiter;
    localparam int          N     = 3;
    localparam int          DEPTH = 16;
    localparam int          W     = 32;
    localparam int          AW    = 4;
    localparam logic [31:0] BASE  = 32'h100;
    localparam int          LIM   = 2 * N + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_mem_arbiter_if #(.NUM_MASTERS(N), .MEM_WIDTH(W)) bus();

    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data;

    apb_mem_arbiter #(
        .NUM_MASTERS(N), .MEM_DEPTH(DEPTH), .MEM_WIDTH(W),
        .BASEADDRESS(BASE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    logic [W-1:0] mem_array [DEPTH];
    logic [W-1:0] init_val  [DEPTH];
    logic [W-1:0] model_mem [DEPTH];
    logic         mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem_array[i] <= init_val[i];
        end else if (mem_wr_en) begin
            mem_array[mem_addr] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem_array[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    bit           act  [N];
    bit           done [N];
    bit           wr_m [N];
    logic [31:0]  adr_m[N];
    logic [W-1:0] dat_m[N];
    int           age  [N];
    int           ord  [$];
    logic [N-1:0] prev_psel;
    logic         prev_rdy;
    int           last_served;
    int           m;
    int           off;
    logic [N*W-1:0] others;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int i, input bit sel, input bit en,
                         input bit wr, input logic [31:0] a,
                         input logic [W-1:0] d);
        bus.psel[i]          = sel;
        bus.penable[i]       = en;
        bus.pwrite[i]        = wr;
        bus.paddr[i*32 +: 32] = a;
        bus.pwdata[i*W +: W] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_m(i, 0, 0, 0, 0, 0);
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hs"}, {bus.pready, bus.pslverr, mem_wr_en, mem_rd_en}, 0);
        check({tag, "_mem"}, {mem_addr, mem_wr_data}, 0);
        check({tag, "_prd"}, |bus.prdata, 0);
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            init_val[i]  = $urandom;
            model_mem[i] = init_val[i];
        end
        mem_load = 1'b1;
        idle_all();
        rst = 1'b1;
        repeat (3) drive();
        mem_load = 1'b0;
        set_m(0, 1, 1, 1, BASE + 2, 32'hFFFF_0000);
        obs();
        check_quiet("rst_busy");
        drive();
        idle_all();
        rst = 1'b0;
        obs();
        check_quiet("post_rst");

        // uncontested write then read back
        drive();
        set_m(0, 1, 0, 1, BASE + 3, 32'hDEADBEEF);
        obs();
        check("w_setup_rdy", bus.pready, 0);
        check("w_setup_en", {mem_wr_en, mem_rd_en}, 0);
        drive();
        bus.penable[0] = 1'b1;
        obs();
        check("w_rdy", bus.pready, 3'b001);
        check("w_en", {mem_wr_en, mem_rd_en}, 2'b10);
        check("w_addr", mem_addr, 3);
        check("w_data", mem_wr_data, 32'hDEADBEEF);
        model_mem[3] = 32'hDEADBEEF;
        drive();
        set_m(0, 1, 0, 0, BASE + 3, 0);
        obs();
        check("r_setup_rdy", bus.pready, 0);
        drive();
        bus.penable[0] = 1'b1;
        obs();
        check("r_rdy", bus.pready, 3'b001);
        check("r_en", {mem_wr_en, mem_rd_en}, 2'b01);
        check("r_data", bus.prdata[W-1:0], 32'hDEADBEEF);
        drive();
        idle_all();

        // simultaneous requests from 0 and 1 after reset
        rst = 1'b1;
        drive();
        rst = 1'b0;
        set_m(0, 1, 0, 0, BASE + 3, 0);
        set_m(1, 1, 0, 0, BASE + 5, 0);
        obs();
        check("rr_setup", bus.pready, 0);
        drive();
        bus.penable[0] = 1'b1;
        bus.penable[1] = 1'b1;
        obs();
        check("rr_first0", bus.pready, 3'b001);
        check("rr_first0_d", bus.prdata[W-1:0], 32'hDEADBEEF);
        drive();
        set_m(0, 1, 0, 0, BASE + 4, 0);
        obs();
        check("rr_gap", bus.pready, 0);
        drive();
        bus.penable[0] = 1'b1;
        obs();
        check("rr_then1", bus.pready, 3'b010);
        check("rr_then1_d", bus.prdata[2*W-1:W], model_mem[5]);
        drive();
        obs();
        check("rr_gap2", bus.pready, 0);
        drive();
        obs();
        check("rr_back0", bus.pready, 3'b001);
        drive();
        idle_all();

        // write one word past the end of memory
        drive();
        set_m(1, 1, 0, 1, BASE + DEPTH, 32'hA5A5_5A5A);
        obs();
        drive();
        bus.penable[1] = 1'b1;
        obs();
        check("oor_rdy", bus.pready, 3'b010);
`ifdef APB_ARB_ADDR_CHECK_EN
        check("oor_err", bus.pslverr, 3'b010);
        check("oor_en", {mem_wr_en, mem_rd_en}, 0);
`else
        check("oor_err", bus.pslverr, 0);
        check("oor_en", {mem_wr_en, mem_rd_en}, 2'b10);
        check("oor_addr", mem_addr, 0);
        model_mem[0] = 32'hA5A5_5A5A;
`endif
        drive();
        idle_all();

        // reset hits a completing write
        drive();
        set_m(0, 1, 0, 1, BASE + 7, 32'h1234_5678);
        obs();
        drive();
        bus.penable[0] = 1'b1;
        rst = 1'b1;
        obs();
        check("rsta_wr", mem_wr_en, 0);
        check("rsta_rdy", bus.pready, 0);
        drive();
        rst = 1'b0;
        idle_all();
        obs();
        check_quiet("rsta_after");
        drive();
        set_m(0, 1, 0, 0, BASE + 7, 0);
        set_m(2, 1, 0, 0, BASE + 8, 0);
        obs();
        drive();
        bus.penable[0] = 1'b1;
        bus.penable[2] = 1'b1;
        obs();
        check("rsta_rr0", bus.pready, 3'b001);
        check("rsta_nowr", bus.prdata[W-1:0], model_mem[7]);
        drive();
        set_m(0, 0, 0, 0, 0, 0);
        obs();
        check("rsta_gap", bus.pready, 0);
        drive();
        obs();
        check("rsta_m2", bus.pready, 3'b100);
        drive();
        idle_all();

        // granted master abandons before its access phase
        drive();
        set_m(0, 1, 0, 0, BASE + 1, 0);
        set_m(1, 1, 0, 0, BASE + 2, 0);
        obs();
        drive();
        set_m(0, 0, 0, 0, 0, 0);
        bus.penable[1] = 1'b1;
        obs();
        check("abort_rdy", bus.pready, 0);
        check("abort_en", {mem_wr_en, mem_rd_en}, 0);
        drive();
        obs();
        check("abort_idle", bus.pready, 0);
        drive();
        obs();
        check("abort_next", bus.pready, 3'b010);
        check("abort_next_d", bus.prdata[2*W-1:W], model_mem[2]);
        drive();
        idle_all();

        // random traffic, fully loaded for the first 40 cycles
        rst = 1'b1;
        drive();
        rst = 1'b0;
        last_served = N - 1;
        prev_psel   = '0;
        prev_rdy    = 1'b0;
        for (int i = 0; i < N; i++) begin
            act[i]  = 1'b0;
            done[i] = 1'b0;
            age[i]  = 0;
        end
        for (int c = 0; c < 600; c++) begin
            drive();
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    act[i]  = 1'b0;
                    done[i] = 1'b0;
                end
                if (act[i]) begin
                    bus.penable[i] = 1'b1;
                    age[i]++;
                end else if (c < 40 || $urandom_range(0, 3) == 0) begin
                    act[i]   = 1'b1;
                    age[i]   = 0;
                    wr_m[i]  = 1'($urandom_range(0, 1));
                    adr_m[i] = BASE + 32'($urandom_range(0, DEPTH - 1));
                    dat_m[i] = $urandom;
                    set_m(i, 1, 0, wr_m[i], adr_m[i], dat_m[i]);
                end else begin
                    set_m(i, 0, 0, 0, 0, 0);
                end
            end
            obs();
            check("excl", mem_wr_en & mem_rd_en, 0);
            check("no_err", bus.pslverr, 0);
            if (|bus.pready) begin
                m = -1;
                for (int i = N - 1; i >= 0; i--) if (bus.pready[i]) m = i;
                check("rdy_onehot", $countones(bus.pready), 1);
                check("rdy_gap", prev_rdy, 0);
                check("grant", m, rr_pick(prev_psel, last_served));
                check("gnt_active", act[m], 1);
                off = int'(adr_m[m] - BASE);
                others = bus.prdata;
                others[m*W +: W] = '0;
                check("prd_other", |others, 0);
                check("acc_addr", mem_addr, off);
                if (wr_m[m]) begin
                    check("wr_en", {mem_wr_en, mem_rd_en}, 2'b10);
                    check("wr_data", mem_wr_data, dat_m[m]);
                    model_mem[off] = dat_m[m];
                end else begin
                    check("rd_en", {mem_wr_en, mem_rd_en}, 2'b01);
                    check("rd_data", bus.prdata[m*W +: W], model_mem[off]);
                end
                if (c < 40) ord.push_back(m);
                last_served = m;
                done[m] = 1'b1;
            end else begin
                check("idle_en", {mem_wr_en, mem_rd_en}, 0);
                check("idle_prd", |bus.prdata, 0);
            end
            for (int i = 0; i < N; i++) begin
                check("wait_bound", act[i] && age[i] > LIM, 0);
            end
            prev_psel = bus.psel;
            prev_rdy  = |bus.pready;
        end
        check("order_cnt", ord.size() >= 6, 1);
        for (int k = 0; k < 6; k++) begin
            check("order", (k < ord.size()) ? ord[k] : -1, k % N);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_mem_arbiter.md
APB_MEM_ARBITER -- requirements
Module: apb_mem_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of APB requester ports sharing one memory (2..8).
REQ-002 Parameter MEM_DEPTH, default 16: words in the shared memory.
REQ-003 Parameter MEM_WIDTH, default 32: data width.
REQ-004 Parameter BASEADDRESS, default 0: byte-free word address of memory word 0.
REQ-005 Parameter ADDR_WIDTH, computed $clog2(MEM_DEPTH): memory address width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 psel  input  NUM_MASTERS  per-master select.
REQ-009 penable  input  NUM_MASTERS  per-master access phase.
REQ-010 pwrite  input  NUM_MASTERS  per-master write (1) / read (0).
REQ-011 paddr  input  NUM_MASTERS*32  per-master word address, master i in bits [32i+31:32i].
REQ-012 pwdata  input  NUM_MASTERS*MEM_WIDTH  per-master write data.
REQ-013 prdata  output  NUM_MASTERS*MEM_WIDTH  per-master read data.
REQ-014 pready  output  NUM_MASTERS  per-master transfer complete.
REQ-015 pslverr  output  NUM_MASTERS  per-master error.
REQ-016 mem_addr  output  ADDR_WIDTH  memory address (paddr - BASEADDRESS, low ADDR_WIDTH bits).
REQ-017 mem_wr_en / mem_rd_en  output  1 each  memory write / read enables.
REQ-018 mem_wr_data  output  MEM_WIDTH  memory write data; mem_rd_data  input  MEM_WIDTH  combinational memory read data.

Function
REQ-019 FSM states IDLE, ACCESS; grant register gnt (index), round-robin pointer rr_ptr.
REQ-020 IDLE: if any psel high, gnt <= first master with psel high searching from rr_ptr upward with wrap; state <= ACCESS; else stay IDLE.
REQ-021 ACCESS, psel[gnt]=1 and penable[gnt]=0: wait, no memory enables, pready all 0.
REQ-022 ACCESS, psel[gnt]=1 and penable[gnt]=1: pready[gnt]=1 combinationally; in-range write drives mem_wr_en=1, in-range read drives mem_rd_en=1; state <= IDLE, rr_ptr <= (gnt+1) mod NUM_MASTERS.
REQ-023 ACCESS, psel[gnt]=0 (aborted): state <= IDLE, no memory enables, rr_ptr unchanged.
REQ-024 mem_addr, mem_wr_data sourced from master gnt while in ACCESS; all memory outputs 0 in IDLE.
REQ-025 prdata[gnt] = mem_rd_data during completing read cycle; all other prdata slices and all non-completing cycles drive 0.
REQ-026 Non-granted masters: pready=0, pslverr=0; they hold their transfer until granted.
REQ-027 Uncontested latency: psel at cycle T, penable at T+1, pready at T+1; one IDLE cycle between consecutive grants.
REQ-028 At most one of mem_wr_en, mem_rd_en high in any cycle; never both.
REQ-029 Simultaneous requests: exactly one grant; each requesting master served within NUM_MASTERS grants.

Reset
REQ-030 rst high at a clock edge: state <= IDLE, gnt <= 0, rr_ptr <= 0, regardless of current state.
REQ-031 During and after reset: pready, pslverr, prdata, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data all 0; an in-progress transfer is dropped without memory write.

Configuration
REQ-032 Macro APB_ARB_ADDR_CHECK_EN defined: address outside [BASEADDRESS, BASEADDRESS+MEM_DEPTH-1] completes with pready=1, pslverr=1, no memory enable, prdata 0.
REQ-033 Macro undefined: no range check; pslverr tied 0; mem_addr = low ADDR_WIDTH bits of (paddr - BASEADDRESS), access always performed.

Verification
REQ-034 Master 0 writes 0xDEADBEEF to addr BASEADDRESS+3 uncontested -> mem_wr_en=1, mem_addr=3, pready[0]=1 at T+1; read back -> prdata[0]=0xDEADBEEF.
REQ-035 Masters 0 and 1 assert psel same cycle after reset -> master 0 served first, master 1 pready two cycles later; repeat -> master 1 served first.
REQ-036 Master 1 write to addr BASEADDRESS+MEM_DEPTH with macro defined -> pready[1]=1, pslverr[1]=1, mem_wr_en=0; macro undefined -> write to mem_addr 0, pslverr 0.
REQ-037 rst asserted in ACCESS with penable[gnt]=1 -> no mem_wr_en that cycle, state IDLE, rr_ptr 0, all outputs 0 next cycle.
REQ-038 Granted master drops psel before penable -> return to IDLE, no memory access, waiting master granted next.
REQ-039 Three masters continuously requesting (NUM_MASTERS=3) -> grant order 0,1,2,0,1,2, never mem_wr_en and mem_rd_en together.
